// File: rtl/fft_pkg.sv
// fft_pkg -- definitions shared by the 16-point FFT output path.
//   NPTS      : number of frequency bins per frame
//   LOG2N     : width of a bin index
//   state_e   : serializer state (IDLE = bank empty, SEND = bank holds a frame)
//   digit_rev : radix-4 two-digit reversal of a bin index
package fft_pkg;

    localparam int NPTS  = 16;
    localparam int LOG2N = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Radix-4 stages leave results in base-4 digit-reversed order; swapping
    // the two base-4 digits of a 4-bit index maps between the two orders.
    function automatic logic [LOG2N-1:0] digit_rev(input logic [LOG2N-1:0] k);
        return {k[1:0], k[3:2]};
    endfunction

endpackage

// File: rtl/fft_round_sat.sv
// fft_round_sat -- converts one wide stage-2 word to the serialized width.
//   y = clamp((x + 2^(SHIFT-1)) >>> SHIFT) to [-2^(OUTW-1), 2^(OUTW-1)-1]
// Ports:
//   x   : input  INW-bit signed word
//   y   : output OUTW-bit signed, rounded (half up) and saturated
//   sat : output 1 when the clamp was applied
module fft_round_sat #(
    parameter int INW   = 48,
    parameter int OUTW  = 16,
    parameter int SHIFT = 4
) (
    input  logic signed [INW-1:0]  x,
    output logic signed [OUTW-1:0] y,
    output logic                   sat
);

    // One guard bit so the rounding add cannot wrap at the positive limit.
    logic signed [INW:0] x_ext;
    logic signed [INW:0] half;
    logic signed [INW:0] sum;
    logic signed [INW:0] shifted;
    logic signed [INW:0] maxv;
    logic signed [INW:0] minv;

    assign x_ext = {x[INW-1], x};

    generate
        if (SHIFT > 0) begin : g_half
            assign half = {{INW{1'b0}}, 1'b1} << (SHIFT - 1);
        end else begin : g_nohalf
            assign half = '0;
        end
    endgenerate

    assign sum     = x_ext + half;
    assign shifted = sum >>> SHIFT;

    // Output range expressed in the wide domain: maxv = 2^(OUTW-1)-1, minv = -2^(OUTW-1).
    assign maxv = signed'({{(INW + 2 - OUTW){1'b0}}, {(OUTW - 1){1'b1}}});
    assign minv = ~maxv;

    always_comb begin
        sat = 1'b0;
        y   = shifted[OUTW-1:0];
        if (shifted > maxv) begin
            sat = 1'b1;
            y   = {1'b0, {(OUTW - 1){1'b1}}};
        end else if (shifted < minv) begin
            sat = 1'b1;
            y   = {1'b1, {(OUTW - 1){1'b0}}};
        end
    end

endmodule

// File: rtl/fft_out_serializer.sv
// fft_out_serializer -- captures a 16-bin complex FFT frame in one cycle,
// scales/saturates every word, then streams the bins out one per beat
// over a valid/ready handshake.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid / in_ready      : frame handshake (in_ready is combinational)
//   yr_in_flat / yi_in_flat  : 16 packed signed INW-bit words, word n at [n*INW +: INW]
//   out_valid / out_ready    : beat handshake
//   out_re / out_im          : scaled, saturated bin
//   out_idx / out_last       : bin index, set on bin 15
//   sat_flag                 : some word of the current frame saturated
// Build option: define FFT_OUT_DIGIT_REV_EN to read the bank in radix-4
// digit-reversed order (out_idx still counts 0..15).
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int INW   = 48,
    parameter int OUTW  = 16,
    parameter int SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [16*INW-1:0]      yr_in_flat,
    input  logic [16*INW-1:0]      yi_in_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [OUTW-1:0] out_re,
    output logic signed [OUTW-1:0] out_im,
    output logic [3:0]             out_idx,
    output logic                   out_last,
    output logic                   sat_flag
);

    logic signed [OUTW-1:0] conv_re [NPTS];
    logic signed [OUTW-1:0] conv_im [NPTS];
    logic [NPTS-1:0]        sat_re;
    logic [NPTS-1:0]        sat_im;

    logic signed [OUTW-1:0] bank_re_reg [NPTS];
    logic signed [OUTW-1:0] bank_im_reg [NPTS];

    state_e                 state_reg, state_next;
    logic [LOG2N-1:0]       cnt_reg, cnt_next;
    logic                   sat_flag_reg;
    logic [LOG2N-1:0]       rd_addr;
    logic                   accept;
    logic                   advance;

    // Conversion of all 32 words in parallel, ahead of the bank.
    genvar gi;
    generate
        for (gi = 0; gi < NPTS; gi++) begin : g_conv
            fft_round_sat #(.INW(INW), .OUTW(OUTW), .SHIFT(SHIFT)) u_re (
                .x   (yr_in_flat[gi*INW +: INW]),
                .y   (conv_re[gi]),
                .sat (sat_re[gi])
            );
            fft_round_sat #(.INW(INW), .OUTW(OUTW), .SHIFT(SHIFT)) u_im (
                .x   (yi_in_flat[gi*INW +: INW]),
                .y   (conv_im[gi]),
                .sat (sat_im[gi])
            );
        end
    endgenerate

    assign accept  = in_valid & in_ready;
    assign advance = out_valid & out_ready;

    // Bank: every entry loads on capture. It is a register file rather than
    // RAM because all 32 words are written in the same cycle.
    generate
        for (gi = 0; gi < NPTS; gi++) begin : g_bank
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bank_re_reg[gi] <= '0;
                    bank_im_reg[gi] <= '0;
                end else if (accept) begin
                    bank_re_reg[gi] <= conv_re[gi];
                    bank_im_reg[gi] <= conv_im[gi];
                end
            end
        end
    endgenerate

    // State register, beat counter and frame saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            sat_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                sat_flag_reg <= |{sat_re, sat_im};
            end
        end
    end

    // Next state. A capture can only happen in SEND on the last accepted
    // beat, which keeps the stream going with no idle cycle between frames.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SEND;
                    cnt_next   = '0;
                end
            end
            SEND: begin
                if (accept) begin
                    state_next = SEND;
                    cnt_next   = '0;
                end else if (advance) begin
                    cnt_next = cnt_reg + LOG2N'(1);
                    if (out_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef FFT_OUT_DIGIT_REV_EN
    assign rd_addr = digit_rev(cnt_reg);
`else
    assign rd_addr = cnt_reg;
`endif

    // Outputs: all derive from registers, so they stay still while stalled.
    always_comb begin
        out_valid = (state_reg == SEND);
        out_idx   = cnt_reg;
        out_last  = (cnt_reg == LOG2N'(NPTS - 1));
        out_re    = bank_re_reg[rd_addr];
        out_im    = bank_im_reg[rd_addr];
        sat_flag  = sat_flag_reg;
        in_ready  = (state_reg == IDLE) | (out_valid & out_ready & out_last);
    end

endmodule
